des_feistel_stage: RTL and testbench

//  Pipelined DES Feistel round, one round per accepted transfer.

---
 rtl/des_feistel_stage.sv | 128 ++++++++++++
 tb/tb_des_feistel_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_feistel_stage.sv
// Two-stage pipelined DES Feistel round with ready/valid on both sides.
// Optional macro DES_LAST_ROUND_EN adds last_in and the unswapped round-16 output form.
module des_feistel_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [47:0] key_in,
`ifdef DES_LAST_ROUND_EN
  input  logic        last_in,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] l_out,
  output logic [31:0] r_out
);

  // Each S-box is 4 rows x 16 cols of nibbles, row-major, entry 0 in the top nibble.
  localparam logic [7:0][255:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [47:0] expand(input logic [31:0] r);
    return {r[0], r[31:27], r[28:23], r[24:19], r[20:15],
            r[16:11], r[12:7], r[8:3], r[4:0], r[31]};
  endfunction

  function automatic logic [31:0] perm(input logic [31:0] s);
    return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
            s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
            s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
            s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  // Row comes from the outer bits, column from the inner four.
  function automatic logic [3:0] sbox_lu(input logic [2:0] n, input logic [5:0] x);
    logic [255:0] tbl;
    logic [5:0]   ridx;
    tbl  = SBOX[~n];
    ridx = ~{x[5], x[0], x[4:1]};
    return tbl[{ridx, 2'b00} +: 4];
  endfunction

  logic        s1_valid_q;
  logic [47:0] x1_q;
  logic [31:0] l1_q, r1_q;
`ifdef DES_LAST_ROUND_EN
  logic        last1_q;
`endif
  logic        out_valid_q;
  logic [31:0] l_out_q, r_out_q;

  logic        s2_ready, accept, load_out;
  logic [7:0][3:0] sb;
  logic [31:0] f_d, l_out_d, r_out_d;

  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign accept   = in_valid && in_ready;
  assign load_out = s1_valid_q && s2_ready;

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    assign sb[7-g] = sbox_lu(3'(g), x1_q[47-6*g -: 6]);
  end

  assign f_d = l1_q ^ perm(sb);

  always_comb begin
    l_out_d = r1_q;
    r_out_d = f_d;
`ifdef DES_LAST_ROUND_EN
    if (last1_q) begin
      l_out_d = f_d;
      r_out_d = r1_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      x1_q       <= '0;
      l1_q       <= '0;
      r1_q       <= '0;
`ifdef DES_LAST_ROUND_EN
      last1_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        x1_q    <= expand(r_in) ^ key_in;
        l1_q    <= l_in;
        r1_q    <= r_in;
`ifdef DES_LAST_ROUND_EN
        last1_q <= last_in;
`endif
      end
      s1_valid_q <= accept || (s1_valid_q && !s2_ready);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      l_out_q     <= '0;
      r_out_q     <= '0;
    end else begin
      if (load_out) begin
        l_out_q <= l_out_d;
        r_out_q <= r_out_d;
      end
      out_valid_q <= load_out || (out_valid_q && !out_ready);
    end
  end

  assign out_valid = out_valid_q;
  assign l_out     = l_out_q;
  assign r_out     = r_out_q;

endmodule

// File: tb/tb_des_feistel_stage.sv
// Directed bench for des_feistel_stage: scoreboard queue filled on accept, drained on output.
module tb_des_feistel_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] l_in = '0, r_in = '0, l_out, r_out;
  logic [47:0] key_in = '0;
`ifdef DES_LAST_ROUND_EN
  logic        last_in = 1'b0;
`endif

  always #5 clk = ~clk;

  des_feistel_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .l_in(l_in), .r_in(r_in), .key_in(key_in),
`ifdef DES_LAST_ROUND_EN
    .last_in(last_in),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .l_out(l_out), .r_out(r_out)
  );

  int E_T[48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                  16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int P_T[32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int SB[8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [31:0] cyc = '0;
  bit          lat_chk = 1'b0, acc = 1'b0, hold_v = 1'b0;
  logic [31:0] exp_l, exp_r, hold_l, hold_r;

  function automatic logic [63:0] model(input logic [31:0] l, r, input logic [47:0] k, input logic lst);
    logic [47:0] x;
    logic [31:0] s, p, nr;
    logic [5:0]  six;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      s[31-4*b -: 4] = 4'(SB[b][{six[5], six[0]} * 16 + six[4:1]]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
    nr = l ^ p;
    return lst ? {nr, r} : {r, nr};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Evaluates this cycle's handshakes just after the inputs settle, then advances one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (hold_v) chk("hold_stable", {l_out, r_out}, {hold_l, hold_r});
    hold_v = out_valid && !out_ready;
    hold_l = l_out;
    hold_r = r_out;
    if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
    if (out_valid && out_ready && q.size() > 0) begin
      e = q.pop_front();
      chk("data", {l_out, r_out}, {e.l, e.r});
      if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd2);
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back('{exp_l, exp_r, cyc});
    @(negedge clk);
    cyc++;
  endtask

  task automatic put_exp(input logic [31:0] l, r, input logic [47:0] k, input logic lst,
                         input logic [31:0] el, er);
    in_valid = 1'b1;
    l_in = l; r_in = r; key_in = k;
`ifdef DES_LAST_ROUND_EN
    last_in = lst;
`endif
    exp_l = el; exp_r = er;
  endtask

  task automatic put(input logic [31:0] l, r, input logic [47:0] k, input logic lst);
    logic [63:0] m;
    m = model(l, r, k, lst);
    put_exp(l, r, k, lst, m[63:32], m[31:0]);
  endtask

  task automatic put_rand(input logic lst);
    put($urandom, $urandom, {16'($urandom), $urandom}, lst);
  endtask

  task automatic wait_accept();
    for (int n = 0; n < 50; n++) begin
      tick();
      if (acc) break;
    end
    chk("accepted", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && q.size() > 0; n++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Three items against a stalled sink, then release.
  task automatic bp3(input logic f0, f1, f2);
    lat_chk = 1'b0;
    out_ready = 1'b0;
    put_rand(f0); tick(); chk("bp_acc1", 64'(acc), 64'd1);
    put_rand(f1); tick(); chk("bp_acc2", 64'(acc), 64'd1);
    put_rand(f2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int n = 0; n < 3; n++) tick();
    chk("bp_still_full", 64'(acc), 64'd0);
    out_ready = 1'b1;
    wait_accept();
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outs", {l_out, r_out}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Known round, two-cycle latency
    out_ready = 1'b1;
    lat_chk = 1'b1;
    put_exp(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b0, 32'hF0AAF0AA, 32'hEF4A6544);
    tick();
    in_valid = 1'b0;
    l_in = $urandom; r_in = $urandom;
    chk("known_not_yet", 64'(out_valid), 64'd0);
    drain();

    // Zero vector
    put_exp('0, '0, '0, 1'b0, 32'h0, 32'hD8D8DBBC);
    wait_accept();
    drain();

    // 16 back-to-back rounds
    begin
      logic [31:0] c0;
      c0 = cyc;
      for (int i = 0; i < 16; i++) begin
        put_rand(1'b0);
        wait_accept();
      end
      chk("stream_cycles", 64'(cyc - c0), 64'd16);
    end
    drain();

    // Backpressure
    bp3(1'b0, 1'b0, 1'b0);

    // Random gaps on both sides
    lat_chk = 1'b0;
    for (int i = 0; i < 80; i++) begin
`ifdef DES_LAST_ROUND_EN
      if (!in_valid && $urandom_range(0, 2) != 0) put_rand(1'($urandom_range(0, 1)));
`else
      if (!in_valid && $urandom_range(0, 2) != 0) put_rand(1'b0);
`endif
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc) in_valid = 1'b0;
    end
    drain();

    // Mid-stream reset with both stages full
    out_ready = 1'b0;
    put_rand(1'b0); tick();
    put_rand(1'b0); tick();
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_outs", {l_out, r_out}, 64'd0);
    q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    lat_chk = 1'b1;
    put_exp(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b0, 32'hF0AAF0AA, 32'hEF4A6544);
    wait_accept();
    drain();

`ifdef DES_LAST_ROUND_EN
    // Final-round form and flag tracking under backpressure
    put_exp(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1, 32'hEF4A6544, 32'hF0AAF0AA);
    wait_accept();
    drain();
    bp3(1'b0, 1'b1, 1'b0);
    bp3(1'b1, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
